irq_priority_ctrl: RTL
======================

Name: irq_priority_ctrl

Overview:
- 4-channel interrupt controller that sits directly downstream of the 4-to-2 priority encoder.
- Captures rising edges on irq[3:0] into a pending register and masks it.
- Feeds the masked pending vector to the encoder and consumes its out/z result.
- Presents the winning vector to the CPU with a valid/ack handshake, tracks in-service state until end-of-interrupt, and bounds ack wait with a timeout counter.

Parameters:
- ACK_TIMEOUT, 15, cycles int_valid may stay high without int_ack before withdrawal (legal 1..255; 8-bit counter).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irq  in  4  raw interrupt request lines, rising-edge sensitive
- mask  in  4  1 = channel enabled; sampled combinationally every cycle
- int_ack  in  1  CPU accepts presented vector
- eoi  in  1  one-cycle pulse, end of interrupt for the in-service channel
- int_valid  out  1  vector presented
- int_vec  out  2  channel number, highest index = highest priority
- in_service  out  4  one-hot channel being serviced, 0 if none
- timeout  out  1  sticky; set on ack timeout, cleared only by reset

Behaviour:
- Reset (async assert, sync release): all of the following go to 0: int_valid, int_vec, in_service, timeout, pending, edge registers, timeout counter. FSM goes to IDLE.
- Input stage: irq_s is irq registered once; irq_d is irq_s delayed one cycle; rise = irq_s & ~irq_d.
- Pending: each edge, pending <= (pending & ~clr) | rise.
  - clr is the one-hot of the accepted vector on the handshake cycle.
  - If set and clear hit the same bit in the same cycle, set wins.
- Encoder input is pending & mask. A masked bit stays pending and becomes visible once unmasked.
- FSM IDLE:
  - If encoder z = 0, latch int_vec <= out, go to REQ, clear the counter.
  - If z = 1, stay in IDLE.
- FSM REQ:
  - int_valid = 1. int_vec is frozen, even if a higher-priority request arrives.
  - int_ack = 1: clear pending[int_vec], set in_service to the one-hot of int_vec, drop int_valid next cycle, go to SERVICE.
  - Otherwise the counter increments. When it reaches ACK_TIMEOUT with no ack: set timeout, drop int_valid, go to IDLE. pending is retained.
  - eoi is ignored in REQ.
- FSM SERVICE:
  - eoi = 1: in_service <= 0, go to IDLE.
  - int_ack is ignored. New edges, including on the in-service channel, still set pending.
  - No nesting: the next request is presented only after eoi.
- Latency (macro off): irq high before edge E0 gives irq_s = 1 at E0, pending at E1, int_valid = 1 after E2.
- Back-to-back: eoi at edge Ek with another unmasked pending bit gives int_valid = 1 after Ek+1.
- Reset mid-operation: everything returns to the reset values immediately. Edges in flight are lost.

Optional Feature:
- IRQ_SYNC_EN defined: irq passes through a 2-flop synchroniser before irq_s. Every irq-to-int_valid latency grows by 2 edges (5 edges total).
- Undefined: single capture register only. Inputs are required to be synchronous to clk.

Decomposition:
- Package irq_ctrl_pkg holds:
  - FSM state typedef: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2.
  - NUM_IRQ = 4 and VEC_W = 2.
- Sub-module: the existing priority_encoder4to2 is instantiated unchanged, with (pending & mask) driving a, and z/out consumed.
- The edge-detect/pending logic stays inline.

Test Plan:
- Reset, mask = 4'hF, irq = 4'b0100 rising before E0 -> int_valid = 1 after E2, int_vec = 2'd2, timeout = 0.
- irq = 4'b0101 simultaneously; ack; eoi -> vector 2 is served first. Vector 0 is presented 1 cycle after eoi.
- mask = 4'b0111, irq[3] rises -> no int_valid. Set mask[3] = 1 -> int_valid with int_vec = 3 two edges later.
- Hold REQ without ack for 15 cycles -> int_valid drops, timeout = 1, FSM re-presents the same vector one cycle later.
- irq[1] re-rises on the exact cycle its ack clears pending -> pending[1] stays set; vector 1 is re-presented after eoi.
- Assert rst_n = 0 mid-SERVICE with in_service = 4'b0010 -> all outputs are 0 asynchronously; the same irq level (no new edge) does not re-pend after release.

Source files
------------

// File: rtl/irq_priority_ctrl_pkg.sv
// Shared types and constants for the 4-channel interrupt priority controller.
package irq_ctrl_pkg;

  localparam int NUM_IRQ = 4;
  localparam int VEC_W   = 2;

  // Presentation FSM: wait for work, present to CPU, wait for end-of-interrupt
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // One-hot expansion of a channel number
  function automatic logic [NUM_IRQ-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [NUM_IRQ-1:0] oh;
    oh    = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_priority_ctrl_prienc.sv
// 4-to-2 priority encoder: highest set index wins, z flags an all-zero input.
module priority_encoder4to2 (
  input  logic [3:0] a,
  output logic [1:0] out,
  output logic       z
);

  // Highest-index-first priority selection
  always_comb begin
    out = 2'd0;
    z   = 1'b0;
    if (a[3])      out = 2'd3;
    else if (a[2]) out = 2'd2;
    else if (a[1]) out = 2'd1;
    else if (a[0]) out = 2'd0;
    else           z   = 1'b1;
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// 4-channel interrupt controller: rising-edge capture into a pending
// register, mask, priority select, valid/ack presentation with an ack
// timeout, and in-service tracking until end-of-interrupt.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on irq.
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_valid,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               timeout
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [NUM_IRQ-1:0] irq_in;

`ifdef IRQ_SYNC_EN
  // Edge history is trustworthy once all four input flops hold real samples
  localparam logic [2:0] ARM_LAST = 3'd4;

  logic [NUM_IRQ-1:0] sync1_reg;
  logic [NUM_IRQ-1:0] sync2_reg;

  // Two-flop synchroniser for asynchronous request lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_in = sync2_reg;
`else
  // Edge history is trustworthy once irq_s and irq_d hold real samples
  localparam logic [2:0] ARM_LAST = 3'd2;

  assign irq_in = irq;
`endif

  logic [NUM_IRQ-1:0] irq_s_reg;
  logic [NUM_IRQ-1:0] irq_d_reg;
  logic [2:0]         arm_reg;
  logic               armed;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic               ack_take;

  state_t             state_reg;
  logic               int_valid_reg;
  logic [VEC_W-1:0]   int_vec_reg;
  logic [NUM_IRQ-1:0] in_service_reg;
  logic               timeout_reg;
  logic [7:0]         cnt_reg;

  logic [VEC_W-1:0]   enc_out;
  logic               enc_z;

  // Capture and delay stages for edge detection, plus warm-up counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s_reg <= '0;
      irq_d_reg <= '0;
      arm_reg   <= '0;
    end else begin
      irq_s_reg <= irq_in;
      irq_d_reg <= irq_s_reg;
      if (arm_reg != ARM_LAST) arm_reg <= arm_reg + 3'd1;
    end
  end

  // A level already high when reset releases is not an edge: suppress
  // rise until the delay line has been filled from live samples.
  assign armed    = (arm_reg == ARM_LAST);
  assign ack_take = (state_reg == REQ) && int_ack;

  // Per-channel edge detect and pending update; a same-cycle set beats the clear
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
    assign rise[gi]         = armed & irq_s_reg[gi] & ~irq_d_reg[gi];
    assign clr[gi]          = ack_take && (int_vec_reg == VEC_W'(gi));
    assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
  end

  // Pending request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  priority_encoder4to2 u_enc (
    .a   (pending_reg & mask),
    .out (enc_out),
    .z   (enc_z)
  );

  // Presentation FSM with registered outputs and ack timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      int_valid_reg  <= 1'b0;
      int_vec_reg    <= '0;
      in_service_reg <= '0;
      timeout_reg    <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!enc_z) begin
            int_vec_reg   <= enc_out;
            int_valid_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // Vector stays frozen here even if a higher channel pends meanwhile
          if (int_ack) begin
            in_service_reg <= vec_onehot(int_vec_reg);
            int_valid_reg  <= 1'b0;
            state_reg      <= SERVICE;
          end else if (cnt_reg == CNT_LAST) begin
            timeout_reg   <= 1'b1;
            int_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service_reg <= '0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          int_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign int_valid  = int_valid_reg;
  assign int_vec    = int_vec_reg;
  assign in_service = in_service_reg;
  assign timeout    = timeout_reg;

endmodule
